// File: rtl/l2_xbar_pkg.sv
// Shared L2 crossbar defaults: payload widths and the channel-index width helper.
package l2_xbar_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned ID_WIDTH   = 16;

  // Index width for n channels, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/l2_rr_prio_sel.sv
// Circular find-first: lowest requester at or above ptr, wrapping to channel 0.
module l2_rr_prio_sel #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [2*N_CH-1:0] dbl;
  logic [2*N_CH-1:0] masked;
  int unsigned       pos;

  // Upper copy of req covers the wrap; bits below ptr in the lower copy are masked off.
  always_comb begin
    dbl   = {req, req};
    pos   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < 2 * N_CH; i++) begin
      masked[i] = dbl[i] & (i >= 32'(ptr));
    end
    for (int unsigned i = 0; i < 2 * N_CH; i++) begin
      if (!found && masked[i]) begin
        found = 1'b1;
        pos   = i;
      end
    end
    idx = IDX_W'((pos >= N_CH) ? (pos - N_CH) : pos);
  end

endmodule

// File: rtl/l2_fanin_req_arb.sv
// N-channel round-robin request fan-in onto one L2 bank port, with the
// selection locked to a refused channel until the slave grants it.
module l2_fanin_req_arb #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned ADDR_WIDTH = l2_xbar_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = l2_xbar_pkg::DATA_WIDTH,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = l2_xbar_pkg::ID_WIDTH,
  parameter int unsigned IDX_W      = l2_xbar_pkg::idx_width(N_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            data_req_i,
  input  logic [N_CH*ADDR_WIDTH-1:0] data_add_i,
  input  logic [N_CH*DATA_WIDTH-1:0] data_wdata_i,
  input  logic [N_CH-1:0]            data_wen_i,
  input  logic [N_CH*BE_WIDTH-1:0]   data_be_i,
  input  logic [N_CH*ID_WIDTH-1:0]   data_ID_i,
  output logic [N_CH-1:0]            data_gnt_o,
  output logic                       data_req_o,
  output logic [ADDR_WIDTH-1:0]      data_add_o,
  output logic [DATA_WIDTH-1:0]      data_wdata_o,
  output logic                       data_wen_o,
  output logic [BE_WIDTH-1:0]        data_be_o,
  output logic [ID_WIDTH-1:0]        data_ID_o,
  input  logic                       data_gnt_i,
  output logic [IDX_W-1:0]           sel_o
);

  logic [IDX_W-1:0] rr_ptr, rr_ptr_d;
  logic             lock, lock_d;
  logic [IDX_W-1:0] lock_idx, lock_idx_d;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_found;
  logic             lock_hit;
  logic [IDX_W-1:0] sel;

  l2_rr_prio_sel #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_prio_sel (
    .req   (data_req_i),
    .ptr   (rr_ptr),
    .idx   (rr_idx),
    .found (rr_found)
  );

  assign data_req_o = |data_req_i;

  // A held lock only wins while the locked master still requests.
  assign lock_hit = lock & data_req_i[lock_idx];
  assign sel      = lock_hit ? lock_idx : (rr_found ? rr_idx : rr_ptr);
  assign sel_o    = sel;

  always_comb begin
    data_gnt_o   = '0;
    data_add_o   = '0;
    data_wdata_o = '0;
    data_wen_o   = 1'b1;
    data_be_o    = '0;
    data_ID_o    = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (sel == IDX_W'(k)) begin
        data_gnt_o[k] = data_gnt_i & data_req_o;
        data_add_o    = data_add_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        data_wdata_o  = data_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        data_wen_o    = data_wen_i[k];
        data_be_o     = data_be_i[k*BE_WIDTH +: BE_WIDTH];
        data_ID_o     = data_ID_i[k*ID_WIDTH +: ID_WIDTH];
      end
    end
  end

  // Grant advances priority past the winner; refusal pins the current winner.
  always_comb begin
    rr_ptr_d   = rr_ptr;
    lock_d     = lock;
    lock_idx_d = lock_idx;
    if (data_req_o) begin
      if (data_gnt_i) begin
        rr_ptr_d = (sel == IDX_W'(N_CH - 1)) ? '0 : sel + IDX_W'(1);
        lock_d   = 1'b0;
      end else begin
        lock_d     = 1'b1;
        lock_idx_d = sel;
      end
    end else begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else begin
      rr_ptr   <= rr_ptr_d;
      lock     <= lock_d;
      lock_idx <= lock_idx_d;
    end
  end

endmodule

// File: tb/tb_l2_fanin_req_arb.sv
// Bench for l2_fanin_req_arb: directed scenarios plus random traffic against a priority-list model.
module tb_l2_fanin_req_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req, wen, gnt_o;
  logic [N*AW-1:0] add;
  logic [N*DW-1:0] wdata;
  logic [N*BW-1:0] be;
  logic [N*IW-1:0] id;
  logic            req_o, wen_o, gnt_i;
  logic [AW-1:0]   add_o;
  logic [DW-1:0]   wdata_o;
  logic [BW-1:0]   be_o;
  logic [IW-1:0]   id_o;
  logic [1:0]      sel_o;

  logic [0:0]    s_req, s_wen, s_gnt_o, s_sel_o;
  logic [AW-1:0] s_add, s_add_o;
  logic [DW-1:0] s_wdata, s_wdata_o;
  logic [BW-1:0] s_be, s_be_o;
  logic [IW-1:0] s_id, s_id_o;
  logic          s_req_o, s_wen_o, s_gnt_i;

  l2_fanin_req_arb #(.N_CH(N)) dut (
    .clk(clk), .rst(rst),
    .data_req_i(req), .data_add_i(add), .data_wdata_i(wdata), .data_wen_i(wen),
    .data_be_i(be), .data_ID_i(id), .data_gnt_o(gnt_o), .data_req_o(req_o),
    .data_add_o(add_o), .data_wdata_o(wdata_o), .data_wen_o(wen_o),
    .data_be_o(be_o), .data_ID_o(id_o), .data_gnt_i(gnt_i), .sel_o(sel_o)
  );

  l2_fanin_req_arb #(.N_CH(1)) dut1 (
    .clk(clk), .rst(rst),
    .data_req_i(s_req), .data_add_i(s_add), .data_wdata_i(s_wdata), .data_wen_i(s_wen),
    .data_be_i(s_be), .data_ID_i(s_id), .data_gnt_o(s_gnt_o), .data_req_o(s_req_o),
    .data_add_o(s_add_o), .data_wdata_o(s_wdata_o), .data_wen_o(s_wen_o),
    .data_be_o(s_be_o), .data_ID_o(s_id_o), .data_gnt_i(s_gnt_i), .sel_o(s_sel_o)
  );

  int errors = 0;
  int checks = 0;

  // Model: priority pointer plus "who was refused last cycle".
  int m_ptr  = 0;
  int m_lock = 0;
  int m_lidx = 0;

  function automatic int model_sel();
    if (m_lock != 0 && req[m_lidx]) return m_lidx;
    for (int d = 0; d < N; d++) begin
      if (req[(m_ptr + d) % N]) return (m_ptr + d) % N;
    end
    return m_ptr;
  endfunction

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    g = '0;
    if (req != 0 && gnt_i) g[model_sel()] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_lock = 0; m_lidx = 0;
  endtask

  task automatic tick();
    int s;
    s = model_sel();
    if (rst) model_reset();
    else if (req == 0) m_lock = 0;
    else if (gnt_i) begin m_ptr = (s + 1) % N; m_lock = 0; end
    else begin m_lock = 1; m_lidx = s; end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    for (int k = 0; k < N; k++) begin
      add[k*AW +: AW]   = $urandom;
      wdata[k*DW +: DW] = {$urandom, $urandom};
      be[k*BW +: BW]    = BW'($urandom);
      id[k*IW +: IW]    = IW'($urandom);
      wen[k]            = 1'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; gnt_i = 1'b0; rand_fields();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL reset_req_o got=%b exp=0", req_o); end
    checks++; if (sel_o !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel_o); end
    req = 4'b0110; gnt_i = 1'b1; #1;
    checks++; if (sel_o !== 2'd1) begin errors++; $display("FAIL reset_lowest_req got=%0d exp=1", sel_o); end
    checks++; if (gnt_o !== 4'b0010) begin errors++; $display("FAIL reset_gnt got=%b exp=0010", gnt_o); end
    @(posedge clk); #1;
    rst = 1'b0; req = '0; gnt_i = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    int c;
    req = 4'b1111; gnt_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_fields(); #1;
      c = i % N;
      checks++; if (sel_o !== 2'(c)) begin errors++; $display("FAIL fair_sel cyc=%0d got=%0d exp=%0d", i, sel_o, c); end
      checks++; if (gnt_o !== 4'(1 << c)) begin errors++; $display("FAIL fair_gnt cyc=%0d got=%b exp=%0d", i, gnt_o, c); end
      checks++;
      if (add_o !== add[c*AW +: AW] || wdata_o !== wdata[c*DW +: DW] || be_o !== be[c*BW +: BW] ||
          id_o !== id[c*IW +: IW] || wen_o !== wen[c]) begin
        errors++; $display("FAIL fair_fields cyc=%0d got_add=%h exp_add=%h got_id=%h exp_id=%h",
                           i, add_o, add[c*AW +: AW], id_o, id[c*IW +: IW]);
      end
      tick();
    end
    req = '0; gnt_i = 1'b0;
  endtask

  task automatic test_wrap();
    req = 4'b0010; gnt_i = 1'b1; #1;
    tick();
    req = 4'b1001; #1;
    checks++; if (sel_o !== 2'd3 || gnt_o !== 4'b1000) begin errors++; $display("FAIL wrap_first got_sel=%0d got_gnt=%b exp=3/1000", sel_o, gnt_o); end
    tick();
    checks++; if (sel_o !== 2'd0 || gnt_o !== 4'b0001) begin errors++; $display("FAIL wrap_second got_sel=%0d got_gnt=%b exp=0/0001", sel_o, gnt_o); end
    tick();
    req = 4'b1111; gnt_i = 1'b0; #1;
    checks++; if (sel_o !== 2'd1) begin errors++; $display("FAIL wrap_ptr got=%0d exp=1", sel_o); end
    gnt_i = 1'b1; #1;
    tick();
    req = '0; gnt_i = 1'b0;
  endtask

  task automatic test_stall();
    logic [AW-1:0] a1;
    req = 4'b0010; gnt_i = 1'b0; #1;
    a1 = add[AW +: AW];
    for (int i = 0; i < 3; i++) begin
      if (i == 1) req = 4'b0011;
      #1;
      checks++; if (sel_o !== 2'd1 || add_o !== a1 || gnt_o !== 4'b0000) begin
        errors++; $display("FAIL stall_hold cyc=%0d got_sel=%0d got_add=%h exp_add=%h got_gnt=%b", i, sel_o, add_o, a1, gnt_o);
      end
      tick();
    end
    gnt_i = 1'b1; #1;
    checks++; if (gnt_o !== 4'b0010) begin errors++; $display("FAIL stall_release got=%b exp=0010", gnt_o); end
    tick();
    checks++; if (sel_o !== 2'd0 || gnt_o !== 4'b0001) begin errors++; $display("FAIL stall_next got_sel=%0d got_gnt=%b exp=0/0001", sel_o, gnt_o); end
    tick();
    req = '0; gnt_i = 1'b0;
  endtask

  task automatic test_drop();
    req = 4'b0100; gnt_i = 1'b0; #1;
    tick();
    req = 4'b1000; #1;
    checks++; if (sel_o !== 2'd3) begin errors++; $display("FAIL drop_sel got=%0d exp=3", sel_o); end
    gnt_i = 1'b1; #1;
    checks++; if (gnt_o !== 4'b1000) begin errors++; $display("FAIL drop_gnt got=%b exp=1000", gnt_o); end
    tick();
    req = '0; gnt_i = 1'b0;
  endtask

  task automatic test_rst_stall();
    req = 4'b1000; gnt_i = 1'b0; #1;
    tick();
    req = 4'b1010; #1;
    checks++; if (sel_o !== 2'd3) begin errors++; $display("FAIL rstl_locked got=%0d exp=3", sel_o); end
    rst = 1'b1; model_reset(); #1;
    checks++; if (sel_o !== 2'd1) begin errors++; $display("FAIL rstl_sel got=%0d exp=1", sel_o); end
    gnt_i = 1'b1; #1;
    checks++; if (gnt_o !== 4'b0010) begin errors++; $display("FAIL rstl_gnt got=%b exp=0010", gnt_o); end
    rst = 1'b0; gnt_i = 1'b0; #1;
    checks++; if (sel_o !== 2'd1) begin errors++; $display("FAIL rstl_after got=%0d exp=1", sel_o); end
    tick();
    gnt_i = 1'b1; #1;
    tick();
    req = '0; gnt_i = 1'b0;
  endtask

  task automatic test_random();
    int s;
    for (int i = 0; i < 300; i++) begin
      req = N'($urandom); gnt_i = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) rand_fields();
      #1;
      s = model_sel();
      checks++; if (sel_o !== 2'(s) || req_o !== (req != 0)) begin
        errors++; $display("FAIL rnd_sel cyc=%0d req=%b got=%0d exp=%0d", i, req, sel_o, s);
      end
      checks++; if (gnt_o !== model_gnt()) begin errors++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", i, gnt_o, model_gnt()); end
      checks++; if (add_o !== add[s*AW +: AW] || wdata_o !== wdata[s*DW +: DW] || id_o !== id[s*IW +: IW] ||
                    be_o !== be[s*BW +: BW] || wen_o !== wen[s]) begin
        errors++; $display("FAIL rnd_fields cyc=%0d got_add=%h exp_add=%h", i, add_o, add[s*AW +: AW]);
      end
      tick();
    end
    req = '0; gnt_i = 1'b0;
  endtask

  task automatic test_single();
    for (int i = 0; i < 24; i++) begin
      s_req = 1'($urandom); s_gnt_i = 1'($urandom);
      s_add = $urandom; s_id = IW'($urandom);
      #1;
      checks++; if (s_gnt_o[0] !== (s_req[0] & s_gnt_i) || s_req_o !== s_req[0]) begin
        errors++; $display("FAIL single_gnt cyc=%0d got=%b exp=%b", i, s_gnt_o, s_req[0] & s_gnt_i);
      end
      checks++; if (s_sel_o !== 1'b0 || s_add_o !== s_add || s_id_o !== s_id) begin
        errors++; $display("FAIL single_sel cyc=%0d got_sel=%b got_add=%h exp_add=%h", i, s_sel_o, s_add_o, s_add);
      end
      tick();
    end
  endtask

  initial begin
    s_req = '0; s_wen = '0; s_add = '0; s_wdata = '0; s_be = '0; s_id = '0; s_gnt_i = 1'b0;
    test_reset();
    test_fairness();
    test_wrap();
    test_stall();
    test_drop();
    test_rst_stall();
    test_random();
    test_single();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l2_fanin_req_arb.md
# l2_fanin_req_arb

Parametrised N-channel request fan-in for the L2 crossbar. It merges N_CH master request ports onto one slave request port. Arbitration is round-robin, with an internal priority pointer that replaces the external RR_FLAG of the 2:1 primitive. It also adds a stall lock: the selected request stays stable while the slave withholds its grant. It sits between the per-bank routing stage and each L2 bank port, and replaces trees of 2:1 fan-in primitives.

## Interface
- N_CH, 4: number of input channels; legal range 1 to 32.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 64: write-data width.
- BE_WIDTH, DATA_WIDTH/8: byte-enable width.
- ID_WIDTH, 16: transaction ID width.
- IDX_W, max(1,$clog2(N_CH)): channel-index width (derived, do not override).

- clk  in  1  clock; every register updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_req_i  in  N_CH  per-channel request.
- data_add_i  in  N_CH*ADDR_WIDTH  packed addresses; channel k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- data_wdata_i  in  N_CH*DATA_WIDTH  packed write data.
- data_wen_i  in  N_CH  write enable, active-low (1 = read).
- data_be_i  in  N_CH*BE_WIDTH  packed byte enables.
- data_ID_i  in  N_CH*ID_WIDTH  packed IDs.
- data_gnt_o  out  N_CH  per-channel grant.
- data_req_o  out  1  merged request.
- data_add_o, data_wdata_o, data_wen_o, data_be_o, data_ID_o  out  as per channel  selected channel's fields.
- data_gnt_i  in  1  slave grant.
- sel_o  out  IDX_W  index of the currently selected channel (debug and response routing).

## Operation
- State registers:
  - rr_ptr[IDX_W], the highest-priority channel.
  - lock, 1 bit.
  - lock_idx[IDX_W].
- Reset values: rr_ptr = 0, lock = 0, lock_idx = 0.
- Outputs are combinational from state and inputs. While rst is asserted, the state is at its reset values, so selection is the lowest-index requester.
- data_req_o = OR of data_req_i.
- Selection, when lock is 1 and data_req_i[lock_idx] is 1: sel = lock_idx.
- Selection, otherwise: sel = the first k with data_req_i[k] = 1, searching circularly from rr_ptr upward (rr_ptr, rr_ptr+1, …, N_CH-1, 0, …).
- Selection, with no request: sel = rr_ptr.
- All data_*_o fields come from channel sel.
- data_gnt_o[k] = data_gnt_i & data_req_o & (k == sel). At most one grant bit is set.
- Clock-edge update when data_req_o & data_gnt_i: rr_ptr ← (sel+1) mod N_CH, lock ← 0.
- Clock-edge update when data_req_o & ~data_gnt_i: lock ← 1, lock_idx ← sel.
- Clock-edge update when data_req_o is 0: lock ← 0; rr_ptr is unchanged.
- Locked channel drops its request before being granted (master protocol violation): selection falls back to normal round-robin in the same cycle. The next edge either clears lock (on grant) or reloads lock_idx with the new sel.
- N_CH = 1: rr_ptr stays 0 and sel_o = 0. The block then behaves as a pass-through with data_gnt_o[0] = data_gnt_i & data_req_i[0].
- rr_ptr wrap: on a grant to channel N_CH-1, rr_ptr becomes 0.

## Timing
- Request-to-grant is combinational: zero cycles when the slave grants immediately.
- State changes take effect one cycle after the clock edge.
- A channel that is refused keeps its selection on every following cycle until it is granted. Payload outputs are stable across stall cycles provided the master holds its fields.
- Fairness: with all channels requesting and the slave always granting, each channel receives exactly one grant every N_CH cycles.
- Simultaneous new request and lock: the locked channel wins regardless of rr_ptr.
- Asynchronous rst mid-stall: lock clears immediately and rr_ptr returns to 0. Selection re-evaluates combinationally, and no grant is lost or duplicated on that edge.

## Structure
- Shared package l2_xbar_pkg holds the default widths (ADDR_WIDTH, DATA_WIDTH, ID_WIDTH) and the idx_width(n) function.
- One sub-module, l2_rr_prio_sel: purely combinational circular find-first.
  - Inputs: req[N_CH], ptr[IDX_W].
  - Outputs: idx[IDX_W], found.
  - Implementation: a doubled request vector masked by ptr.
- The top level contains the state registers, the lock mux and the output muxes.
- Expected size is about 150–250 RTL lines.

## Test plan
- Reset, N_CH=4, all requests high, data_gnt_i=1 for 8 cycles → grants go to channels 0,1,2,3,0,1,2,3, with matching sel_o and fields.
- rr_ptr=2, requests on channels 0 and 3 only, grant=1 → channel 3 is granted first, then channel 0, and rr_ptr ends at 1.
- Channel 1 requests and grant=0 for 3 cycles, while channel 0 raises its request in cycle 2 → sel_o stays 1, data_add_o stays at channel 1's address, and channel 1 is granted when grant rises. Next cycle channel 0 wins.
- Locked channel 2 drops its request while channel 3 requests → sel switches to 3 in the same cycle, with no grant to channel 2.
- rst pulse during a lock at channel 3 → lock=0 and rr_ptr=0 immediately. With requests on channels 1 and 3, sel = 1.
- N_CH=1 → data_gnt_o[0] follows data_req_i[0] & data_gnt_i exactly, and sel_o = 0 always.
